// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M multi-cycle multiplier: op encodings,
// FSM state encodings and the operation-select width.
package mul_pkg;

   localparam int OP_W = 2;

   localparam logic [1:0] MUL_OP_MUL    = 2'd0;
   localparam logic [1:0] MUL_OP_MULH   = 2'd1;
   localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
   localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL0 = 3'd1;
   localparam logic [2:0] ST_MUL1 = 3'd2;
   localparam logic [2:0] ST_MUL2 = 3'd3;
   localparam logic [2:0] ST_MUL3 = 3'd4;
   localparam logic [2:0] ST_SIGN = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_MUL0 = ST_MUL0,
      S_MUL1 = ST_MUL1,
      S_MUL2 = ST_MUL2,
      S_MUL3 = ST_MUL3,
      S_SIGN = ST_SIGN,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/dsp_mul16x16u.sv
// Unsigned 16x16 combinational multiplier; behavioural stand-in for an SB_MAC16
// configured with A_SIGNED=B_SIGNED=0 and every input/output register bypassed.
module dsp_mul16x16u (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   assign p = 32'(a) * 32'(b);

endmodule

// File: rtl/dsp_mul_sequencer.sv
// RV32M MUL/MULH/MULHSU/MULHU unit: four passes through one unsigned 16x16
// multiplier on operand magnitudes, accumulated into 64 bits, then sign-fixed.
module dsp_mul_sequencer #(
   parameter int OP_W = mul_pkg::OP_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OP_W-1:0] req_op,
   input  logic [31:0]     req_a,
   input  logic [31:0]     req_b,
   input  logic            kill,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_data
);

   import mul_pkg::*;

   state_t          state_reg, state_next;
   logic [OP_W-1:0] op_reg;
   logic [31:0]     a_mag_reg, b_mag_reg;
   logic            neg_reg;
   logic [63:0]     acc_reg;

   logic            a_neg, b_neg;
   logic [31:0]     a_mag_next, b_mag_next;
   logic [15:0]     mul_a, mul_b;
   logic [31:0]     prod;
   logic [63:0]     prod_aligned;

   // Only MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
   // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
   always_comb begin
      a_neg      = req_a[31] && ((req_op == MUL_OP_MULH) || (req_op == MUL_OP_MULHSU));
      b_neg      = req_b[31] && (req_op == MUL_OP_MULH);
      a_mag_next = a_neg ? (32'd0 - req_a) : req_a;
      b_mag_next = b_neg ? (32'd0 - req_b) : req_b;
   end

   always_comb begin
      mul_a        = a_mag_reg[15:0];
      mul_b        = b_mag_reg[15:0];
      prod_aligned = {32'd0, prod};
      case (state_reg)
         S_MUL1: begin
            mul_b        = b_mag_reg[31:16];
            prod_aligned = {16'd0, prod, 16'd0};
         end
         S_MUL2: begin
            mul_a        = a_mag_reg[31:16];
            prod_aligned = {16'd0, prod, 16'd0};
         end
         S_MUL3: begin
            mul_a        = a_mag_reg[31:16];
            mul_b        = b_mag_reg[31:16];
            prod_aligned = {prod, 32'd0};
         end
         default: ;
      endcase
   end

   dsp_mul16x16u u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (prod)
   );

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_reg)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = S_MUL0;
         end
         S_MUL0: state_next = kill ? S_IDLE : S_MUL1;
         S_MUL1: state_next = kill ? S_IDLE : S_MUL2;
         S_MUL2: state_next = kill ? S_IDLE : S_MUL3;
         S_MUL3: state_next = kill ? S_IDLE : S_SIGN;
         S_SIGN: state_next = kill ? S_IDLE : S_DONE;
         S_DONE: begin
            resp_valid = 1'b1;
            if (kill || resp_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         op_reg    <= '0;
         a_mag_reg <= '0;
         b_mag_reg <= '0;
         neg_reg   <= 1'b0;
         acc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (req_valid) begin
                  op_reg    <= req_op;
                  a_mag_reg <= a_mag_next;
                  b_mag_reg <= b_mag_next;
                  neg_reg   <= a_neg ^ b_neg;
                  acc_reg   <= '0;
               end
            end
            S_MUL0, S_MUL1, S_MUL2, S_MUL3: acc_reg <= acc_reg + prod_aligned;
            S_SIGN: if (neg_reg) acc_reg <= 64'd0 - acc_reg;
            default: ;
         endcase
      end
   end

   // Driven purely from registers, so it holds steady under backpressure.
   assign resp_data = (op_reg == MUL_OP_MUL) ? acc_reg[31:0] : acc_reg[63:32];

endmodule

// File: tb/tb_dsp_mul_sequencer.sv
// Directed self-checking bench for dsp_mul_sequencer: results, latency,
// backpressure, kill behaviour and asynchronous reset.
module tb_dsp_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        kill;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dsp_mul_sequencer #(.OP_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .kill       (kill),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data)
   );

   // Presents one request across an edge; returns #1 after the accepting edge (MUL0).
   task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // lat counts cycles after the accept cycle; 30 means the response never came.
   task automatic wait_resp(output int lat);
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_req_ready: got %b expected 1", req_ready);
      end
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
      end
      checks++;
      if (resp_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_resp_data: got %h expected 00000000", resp_data);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mul_basic();
      int lat;
      resp_ready = 1'b1;
      start_req(2'd0, 32'h00000007, 32'hFFFFFFFD);
      wait_resp(lat);
      checks++;
      if (lat != 6) begin
         failures++;
         $display("FAIL mul_latency: got %0d expected 6", lat);
      end
      checks++;
      if (resp_data !== 32'hFFFFFFEB) begin
         failures++;
         $display("FAIL mul_7x-3: got %h expected ffffffeb", resp_data);
      end
      $display("txn MUL 00000007 x fffffffd -> %h lat=%0d", resp_data, lat);
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL mul_return_idle: got ready=%b valid=%b expected ready=1 valid=0",
                  req_ready, resp_valid);
      end
   endtask

   task automatic test_high_ops();
      logic [1:0]  ops [5] = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd3};
      logic [31:0] as  [5] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] bs  [5] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] exp [5] = '{32'h40000000, 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
      int lat;
      resp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start_req(ops[i], as[i], bs[i]);
         wait_resp(lat);
         checks++;
         if (lat != 6 || resp_data !== exp[i]) begin
            failures++;
            $display("FAIL high_op_%0d: got %h lat=%0d expected %h lat=6", i, resp_data, lat, exp[i]);
         end
         $display("txn op=%0d %h x %h -> %h lat=%0d", ops[i], as[i], bs[i], resp_data, lat);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      resp_ready = 1'b0;
      start_req(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_resp(lat);
      checks++;
      if (lat != 6 || resp_data !== 32'hFFFFFFFE) begin
         failures++;
         $display("FAIL bp_first: got %h lat=%0d expected fffffffe lat=6", resp_data, lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (resp_data !== 32'hFFFFFFFE || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold_%0d: got data=%h valid=%b ready=%b expected fffffffe 1 0",
                     i, resp_data, resp_valid, req_ready);
         end
      end
      $display("txn MULHU backpressured -> %h", resp_data);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", req_ready, resp_valid);
      end
      start_req(2'd0, 32'd2, 32'd3);
      wait_resp(lat);
      checks++;
      if (lat != 6 || resp_data !== 32'd6) begin
         failures++;
         $display("FAIL bp_next_req: got %h lat=%0d expected 00000006 lat=6", resp_data, lat);
      end
      $display("txn MUL 2 x 3 after backpressure -> %h", resp_data);
      @(posedge clk);
      #1;
   endtask

   task automatic test_kill_mul2();
      int  lat;
      logic seen;
      resp_ready = 1'b1;
      start_req(2'd0, 32'h00001234, 32'h00005678);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL kill_mul2_idle: got ready=%b valid=%b expected 1 0", req_ready, resp_valid);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid === 1'b1) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL kill_mul2_no_resp: got resp_valid pulse expected none");
      end
      start_req(2'd0, 32'd3, 32'd5);
      wait_resp(lat);
      checks++;
      if (lat != 6 || resp_data !== 32'd15) begin
         failures++;
         $display("FAIL kill_then_mul: got %h lat=%0d expected 0000000f lat=6", resp_data, lat);
      end
      $display("txn killed MUL then MUL 3 x 5 -> %h", resp_data);
      @(posedge clk);
      #1;
   endtask

   task automatic test_kill_idle_done();
      int lat;
      resp_ready = 1'b0;
      kill       = 1'b1;
      start_req(2'd1, 32'hFFFFFFFE, 32'h00000003);
      kill = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL kill_idle_accept: got ready=%b expected 0", req_ready);
      end
      wait_resp(lat);
      checks++;
      if (lat != 6 || resp_data !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL kill_idle_result: got %h lat=%0d expected ffffffff lat=6", resp_data, lat);
      end
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL kill_done_drop: got valid=%b ready=%b expected 0 1", resp_valid, req_ready);
      end
      $display("txn MULH -2 x 3 killed in DONE");
      resp_ready = 1'b1;
   endtask

   task automatic test_async_reset();
      int lat;
      resp_ready = 1'b1;
      start_req(2'd3, 32'hDEADBEEF, 32'h12345678);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin
         failures++;
         $display("FAIL async_reset: got ready=%b valid=%b data=%h expected 1 0 00000000",
                  req_ready, resp_valid, resp_data);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_req(2'd3, 32'h00010000, 32'h00010000);
      wait_resp(lat);
      checks++;
      if (lat != 6 || resp_data !== 32'h00000001) begin
         failures++;
         $display("FAIL post_reset_mulhu: got %h lat=%0d expected 00000001 lat=6", resp_data, lat);
      end
      $display("txn MULHU 00010000 x 00010000 after reset -> %h", resp_data);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'd0;
      req_a      = 32'd0;
      req_b      = 32'd0;
      kill       = 1'b0;
      resp_ready = 1'b1;
      #2;
      test_reset();
      test_mul_basic();
      test_high_ops();
      test_backpressure();
      test_kill_mul2();
      test_kill_idle_done();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dsp_mul_sequencer.md
# dsp_mul_sequencer

Multi-cycle 32×32 multiply unit for the RV32M MUL/MULH/MULHSU/MULHU instructions. It time-shares one unsigned 16×16 iCE40 SB_MAC16 multiplier over four passes and accumulates the partial products into a 64-bit register. It sits beside the integer ALU in the execute stage and talks to the pipeline through a valid/ready request/response pair. It also takes a kill input so the pipeline can flush an in-flight operation.

## Interface

Parameters:
- `OP_W`, 2: width of the operation select.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low (already decided).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_op`  in  OP_W  operation: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- `req_a`  in  32  rs1 operand.
- `req_b`  in  32  rs2 operand.
- `kill`  in  1  abort the in-flight operation; no response is produced.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_data`  out  32  result: low word for MUL, high word otherwise.

## Operation

States are IDLE, MUL0, MUL1, MUL2, MUL3, SIGN, DONE.

- **IDLE:** `req_ready`=1. When `req_valid` is high, capture the operands, then go to MUL0:
  - Capture the op.
  - Capture |a| and |b| as 32-bit unsigned magnitudes. `a` is signed for MULH/MULHSU. `b` is signed for MULH only.
  - Capture `neg` = sign(a) XOR sign(b), restricted to the signed operands.
  - Clear the 64-bit accumulator.
- **MUL0:** acc += aL·bL.
- **MUL1:** acc += aL·bH << 16.
- **MUL2:** acc += aH·bL << 16.
- **MUL3:** acc += aH·bH << 32.
- **SIGN:** if `neg`, acc = −acc (two's complement over 64 bits). Then go to DONE.
- **DONE:** `resp_valid`=1. `resp_data` = acc[31:0] for MUL, acc[63:32] otherwise. Stay in DONE until `resp_ready`, then go to IDLE.

Arithmetic rules:
- All accumulator additions are 64-bit and wrap mod 2^64. With magnitude operands no real overflow can occur.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned.

Kill:
- `kill` in MUL0..SIGN forces IDLE on the next edge and suppresses the response.
- `kill` in DONE drops the result: IDLE next edge, and `resp_valid` falls.
- `kill` in IDLE is ignored, and a request presented in the same cycle is still accepted.

Reset:
- Asynchronous `rst_n` low forces IDLE immediately from any state.
- Reset output values: `req_ready`=1, `resp_valid`=0, `resp_data`=0.
- Accumulator and operand registers clear to 0. Any in-flight operation is lost.

`resp_data` holds stable while `resp_valid`=1 and `resp_ready`=0.

## Timing

- Request accepted on edge T (IDLE, `req_valid`=1).
- MUL0..MUL3 occupy cycles T+1..T+4, SIGN is T+5, and `resp_valid` rises at T+6.
- Latency: 6 cycles from accept to response.
- Minimum issue interval: 7 cycles. DONE and `resp_ready` at T+6 returns to IDLE at T+7, where the next request can be accepted.
- `req_ready` is combinational from state only and never depends on `req_valid`.
- The multiplier sub-module is combinational: SB_MAC16 with all input/output registers disabled. Each partial product is added to the accumulator in the same cycle.

## Structure

- Shared package `mul_pkg` holds:
  - op encodings `MUL_OP_MUL`/`MULH`/`MULHSU`/`MULHU`;
  - state encoding localparams;
  - `OP_W`.
- Sub-module `dsp_mul16x16u` wraps SB_MAC16 (`A_SIGNED`=`B_SIGNED`=0, no pipeline registers), with 16-bit A/B in and 32-bit product out. A behavioural model of the same module is used for simulation.
- The sequencer contains:
  - the FSM;
  - operand-half muxes (aL/aH, bL/bH by state);
  - a shift-align mux for the product;
  - the 64-bit accumulator;
  - the negate logic.

## Test plan

- MUL 0x00000007 × 0xFFFFFFFD (−3) → `resp_data`=0xFFFFFFEB, `resp_valid` rising exactly 6 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU of the same operands → 0x40000000. MULH 0x80000000 × 0xFFFFFFFF → 0x00000000.
- MULHSU 0xFFFFFFFF (−1) × 0xFFFFFFFF (unsigned) → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid` rises:
  - `resp_data` stays stable and `req_ready` stays 0;
  - on `resp_ready`=1, IDLE follows the next cycle;
  - a new request is accepted the cycle after that.
- Kill in MUL2 → IDLE next cycle, no `resp_valid` pulse. The next request MUL 3×5 returns 15 with no leftover accumulator state.
- Assert `rst_n` low asynchronously mid-MUL1 → `req_ready`=1 and `resp_valid`=0 immediately, without waiting for a clock edge. After release, MULHU 0x00010000 × 0x00010000 returns 0x00000001.
